sysref_gate_monitor: RTL and testbench
======================================

// Module: sysref_gate_monitor
// PURPOSE
//  Consumes the registered SYSREF level produced by the clock-signaling stage in the master_clock domain.
//  Measures the SYSREF period, declares lock after consecutive in-tolerance periods, and flags period errors.
//  Passes a bounded, whole-pulse burst of SYSREF to the RF data converter on request (arm), then gates it off.
//  Sits between the clock-signaling stage and the RFDC user_sysref_adc/dac inputs.
// PARAMETERS
//  PERIOD_W    16  width of period counter/measurement
//  EXP_PERIOD  64  expected SYSREF period in master_clock cycles (500 MHz / 7.8125 MHz)
//  TOL         1   allowed |measured - EXP_PERIOD| in cycles
//  LOCK_CNT    4   consecutive good periods required to assert locked (1..255)
//  BURST_EDGES 8   SYSREF pulses passed per arm (1..255)
// PORTS
//  master_clock   in   1         single clock for all logic
//  aresetn        in   1         asynchronous active-low reset
//  user_sysref    in   1         SYSREF level from clock-signaling stage
//  arm            in   1         1-cycle pulse: request one gated burst
//  disarm         in   1         1-cycle pulse: abort/return gate to idle
//  clear_err      in   1         1-cycle pulse: clear err_sticky
//  sysref_gated   out  1         gated SYSREF to RFDC (registered)
//  locked         out  1         period lock status
//  period_meas    out  PERIOD_W  last measured period (cycles)
//  period_valid   out  1         1-cycle strobe when period_meas updates
//  err_sticky     out  1         bad period or timeout seen while locked
//  gate_busy      out  1         gate FSM in WAIT or PASS
//  burst_done     out  1         level: gate FSM in DONE
// BEHAVIOUR
//  Reset: all outputs 0, FSMs to UNLOCKED/IDLE, counters 0, first_seen=0.
//  Input: s1<=user_sysref, s2<=s1, s3<=s2; rise=s2&~s3, fall=~s2&s3.
//  Period cnt: +1 per cycle, saturates at 2^PERIOD_W-1; on rise: period_meas<=cnt, period_valid=1 next cycle, cnt<=1.
//  First rise after reset/timeout only sets first_seen; no measurement, no strobe.
//  good = |period_meas - EXP_PERIOD| <= TOL (unsigned compare, no wrap).
//  Timeout: cnt reaching saturation = one bad event; clears first_seen; no period_valid.
//  Lock FSM: UNLOCKED -(first good)-> TRACK; TRACK: good => good_cnt+1, bad => UNLOCKED;
//   good_cnt==LOCK_CNT => LOCKED (locked=1 same cycle as state). LOCKED: bad/timeout => UNLOCKED, err_sticky<=1.
//  err_sticky: set has priority over simultaneous clear_err.
//  Gate FSM: IDLE -arm-> WAIT; WAIT & locked & rise => PASS (open_now); PASS counts rises incl. the opening one;
//   PASS & fall & pulse_cnt==BURST_EDGES => DONE; DONE -arm-> WAIT. arm ignored in WAIT/PASS.
//  sysref_gated <= s2 & (state==PASS | open_now): whole pulses only, latency 3 cycles from user_sysref.
//  disarm: IDLE/WAIT/DONE => IDLE next cycle; in PASS closes at next fall (no runt) then IDLE. disarm beats arm.
//  Lock loss in WAIT: keep waiting. In PASS: finish current pulse at fall, go IDLE (not DONE), burst_done stays 0.
//  gate_busy = WAIT|PASS; burst_done = DONE.
//  Reset mid-burst: sysref_gated drops asynchronously with aresetn, lock restarts from UNLOCKED.
// TESTING
//  Period 64, duty 8 hi, 10 pulses -> period_valid on pulses 2..10 with 64; locked asserted after 5th rise.
//  Locked, inject one period of 70 -> locked=0, err_sticky=1; clear_err pulse -> err_sticky=0.
//  Locked, arm -> sysref_gated carries exactly 8 full 8-cycle pulses, 3-cycle delay; burst_done=1 after.
//  Arm while unlocked, then start SYSREF -> no gated pulse until locked; first gated pulse on first rise after lock.
//  Stop SYSREF while locked for 2^16 cycles -> timeout: locked=0, err_sticky=1, no period_valid.
//  disarm mid-pulse in PASS -> current pulse completes full 8 cycles, then gate IDLE, burst_done=0.

Source files
------------

// File: rtl/sysref_gate_monitor.sv
// SYSREF period monitor with lock detection and a whole-pulse burst gate toward the RFDC.
// Single clock domain; user_sysref arrives already registered from the clock-signaling stage.
module sysref_gate_monitor #(
    parameter int unsigned PERIOD_W    = 16,
    parameter int unsigned EXP_PERIOD  = 64,
    parameter int unsigned TOL         = 1,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned BURST_EDGES = 8
) (
    input  logic                master_clock,
    input  logic                aresetn,
    input  logic                user_sysref,
    input  logic                arm,
    input  logic                disarm,
    input  logic                clear_err,
    output logic                sysref_gated,
    output logic                locked,
    output logic [PERIOD_W-1:0] period_meas,
    output logic                period_valid,
    output logic                err_sticky,
    output logic                gate_busy,
    output logic                burst_done
);

    localparam logic [PERIOD_W-1:0] CntMax     = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] CntNearMax = {{(PERIOD_W-1){1'b1}}, 1'b0};
    localparam logic [PERIOD_W-1:0] ExpP       = PERIOD_W'(EXP_PERIOD);
    localparam logic [PERIOD_W-1:0] TolP       = PERIOD_W'(TOL);
    localparam logic [7:0]          LockCnt8   = 8'(LOCK_CNT);
    localparam logic [7:0]          Burst8     = 8'(BURST_EDGES);

    typedef enum logic [1:0] {LkUnlocked, LkTrack, LkLocked} lock_e;
    typedef enum logic [1:0] {GtIdle, GtWait, GtPass, GtDone} gate_e;

    logic                s1_q, s2_q, s3_q;
    logic                rise, fall;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, meas_q, meas_d, diff;
    logic                pv_q, pv_d, to_q, to_d, first_q, first_d;
    logic                good, meas_good, bad_evt;
    lock_e               lock_q, lock_d;
    logic [7:0]          good_cnt_q, good_cnt_d;
    logic                err_q, err_d;
    gate_e               gate_q, gate_d;
    logic [7:0]          pulse_cnt_q, pulse_cnt_d;
    logic                abort_q, abort_d, open_now, gated_q, gated_d;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Period counter: the first rise after reset or timeout only re-arms the measurement.
    always_comb begin
        cnt_d   = cnt_q;
        meas_d  = meas_q;
        pv_d    = 1'b0;
        to_d    = 1'b0;
        first_d = first_q;
        if (rise) begin
            cnt_d = {{(PERIOD_W-1){1'b0}}, 1'b1};
            if (first_q) begin
                meas_d = cnt_q;
                pv_d   = 1'b1;
            end else begin
                first_d = 1'b1;
            end
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntNearMax) begin
                to_d    = 1'b1;
                first_d = 1'b0;
            end
        end
    end

    always_comb begin
        diff      = (meas_q >= ExpP) ? (meas_q - ExpP) : (ExpP - meas_q);
        good      = (diff <= TolP);
        meas_good = pv_q & good;
        bad_evt   = (pv_q & ~good) | to_q;
        err_d     = err_q;
        if (lock_q == LkLocked && bad_evt) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge master_clock or negedge aresetn) begin
        if (!aresetn) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            meas_q  <= '0;
            pv_q    <= 1'b0;
            to_q    <= 1'b0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            gated_q <= 1'b0;
        end else begin
            s1_q    <= user_sysref;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            pv_q    <= pv_d;
            to_q    <= to_d;
            first_q <= first_d;
            err_q   <= err_d;
            gated_q <= gated_d;
        end
    end

    // Lock FSM
    always_ff @(posedge master_clock or negedge aresetn) begin
        if (!aresetn) begin
            lock_q     <= LkUnlocked;
            good_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    always_comb begin
        lock_d     = lock_q;
        good_cnt_d = good_cnt_q;
        unique case (lock_q)
            LkUnlocked: begin
                if (meas_good) begin
                    good_cnt_d = 8'd1;
                    lock_d     = (LOCK_CNT <= 1) ? LkLocked : LkTrack;
                end
            end
            LkTrack: begin
                if (bad_evt) begin
                    lock_d     = LkUnlocked;
                    good_cnt_d = '0;
                end else if (meas_good) begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_d == LockCnt8) lock_d = LkLocked;
                end
            end
            LkLocked: begin
                if (bad_evt) begin
                    lock_d     = LkUnlocked;
                    good_cnt_d = '0;
                end
            end
            default: lock_d = LkUnlocked;
        endcase
    end

    always_comb begin
        locked = (lock_q == LkLocked);
    end

    // Gate FSM
    always_ff @(posedge master_clock or negedge aresetn) begin
        if (!aresetn) begin
            gate_q      <= GtIdle;
            pulse_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            gate_q      <= gate_d;
            pulse_cnt_q <= pulse_cnt_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        gate_d      = gate_q;
        pulse_cnt_d = pulse_cnt_q;
        abort_d     = abort_q;
        unique case (gate_q)
            GtIdle: if (arm && !disarm) gate_d = GtWait;
            GtWait: begin
                if (disarm) begin
                    gate_d = GtIdle;
                end else if (open_now) begin
                    gate_d      = GtPass;
                    pulse_cnt_d = 8'd1;
                    abort_d     = 1'b0;
                end
            end
            GtPass: begin
                if (rise) pulse_cnt_d = pulse_cnt_q + 8'd1;
                // Abort only while SYSREF is low so the pulse in flight is never truncated.
                if (disarm || abort_q || !locked) begin
                    if (!s2_q) begin
                        gate_d  = GtIdle;
                        abort_d = 1'b0;
                    end else begin
                        abort_d = 1'b1;
                    end
                end else if (fall && pulse_cnt_q == Burst8) begin
                    gate_d = GtDone;
                end
            end
            GtDone: begin
                if (disarm) gate_d = GtIdle;
                else if (arm) gate_d = GtWait;
            end
            default: gate_d = GtIdle;
        endcase
    end

    always_comb begin
        open_now   = (gate_q == GtWait) & locked & rise & ~disarm;
        gate_busy  = (gate_q == GtWait) | (gate_q == GtPass);
        burst_done = (gate_q == GtDone);
        gated_d    = s2_q & ((gate_q == GtPass) | open_now);
    end

    assign sysref_gated = gated_q;
    assign period_meas  = meas_q;
    assign period_valid = pv_q;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_sysref_gate_monitor.sv
// Directed bench for sysref_gate_monitor: table of SYSREF periods with expected lock/error
// state, plus hand sequences for burst gating, disarm, timeout and reset mid-burst.
module tb_sysref_gate_monitor;

    logic        master_clock = 1'b0;
    logic        aresetn      = 1'b0;
    logic        user_sysref  = 1'b0;
    logic        arm          = 1'b0;
    logic        disarm       = 1'b0;
    logic        clear_err    = 1'b0;
    logic        sysref_gated, locked, period_valid, err_sticky, gate_busy, burst_done;
    logic [15:0] period_meas;

    sysref_gate_monitor dut (
        .master_clock (master_clock),
        .aresetn      (aresetn),
        .user_sysref  (user_sysref),
        .arm          (arm),
        .disarm       (disarm),
        .clear_err    (clear_err),
        .sysref_gated (sysref_gated),
        .locked       (locked),
        .period_meas  (period_meas),
        .period_valid (period_valid),
        .err_sticky   (err_sticky),
        .gate_busy    (gate_busy),
        .burst_done   (burst_done)
    );

    always #5 master_clock = ~master_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: period_valid strobes, gated pulse count, length and alignment.
    int         pv_cnt  = 0;
    int         gp_cnt  = 0;
    int         run     = 0;
    logic       g_prev  = 1'b0;
    logic [7:0] hist    = '0;

    always @(negedge master_clock) begin
        hist = {hist[6:0], user_sysref};
        if (!aresetn) begin
            run    = 0;
            g_prev = 1'b0;
        end else begin
            if (period_valid) pv_cnt++;
            if (sysref_gated && !g_prev) check("gated_align", int'({hist[4], hist[3]}), 1);
            if (sysref_gated) begin
                run++;
            end else if (g_prev) begin
                check("gated_len", run, 8);
                gp_cnt++;
                run = 0;
            end
            g_prev = sysref_gated;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge master_clock);
            #1;
            arm       = 1'b0;
            disarm    = 1'b0;
            clear_err = 1'b0;
        end
    endtask

    // One SYSREF pulse of 'hi' high cycles within 'period' cycles; control pulses at given offsets.
    task automatic send_pulse(input int period, input int hi, input int arm_at,
                              input int disarm_at, input int clear_at);
        for (int i = 0; i < period; i++) begin
            @(posedge master_clock);
            #1;
            user_sysref = (i < hi);
            arm         = (i == arm_at);
            disarm      = (i == disarm_at);
            clear_err   = (i == clear_at);
        end
    endtask

    typedef struct {
        int   period;
        int   pv_inc;
        int   meas;
        logic lk;
        logic err;
    } vec_t;

    vec_t vecs[16];
    int   pv0, gp0;

    initial begin
        vecs[0]  = '{64, 0,  0, 1'b0, 1'b0};
        vecs[1]  = '{64, 1, 64, 1'b0, 1'b0};
        vecs[2]  = '{64, 1, 64, 1'b0, 1'b0};
        vecs[3]  = '{64, 1, 64, 1'b0, 1'b0};
        vecs[4]  = '{64, 1, 64, 1'b1, 1'b0};
        vecs[5]  = '{64, 1, 64, 1'b1, 1'b0};
        vecs[6]  = '{64, 1, 64, 1'b1, 1'b0};
        vecs[7]  = '{64, 1, 64, 1'b1, 1'b0};
        vecs[8]  = '{64, 1, 64, 1'b1, 1'b0};
        vecs[9]  = '{70, 1, 64, 1'b1, 1'b0};
        vecs[10] = '{64, 1, 70, 1'b0, 1'b1};
        vecs[11] = '{65, 1, 64, 1'b0, 1'b1};
        vecs[12] = '{63, 1, 65, 1'b0, 1'b1};
        vecs[13] = '{64, 1, 63, 1'b0, 1'b1};
        vecs[14] = '{66, 1, 64, 1'b1, 1'b1};
        vecs[15] = '{64, 1, 66, 1'b0, 1'b1};

        repeat (3) @(negedge master_clock);
        check("rst_gated", int'(sysref_gated), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_meas", int'(period_meas), 0);
        check("rst_pv", int'(period_valid), 0);
        check("rst_err", int'(err_sticky), 0);
        check("rst_busy", int'(gate_busy), 0);
        check("rst_done", int'(burst_done), 0);
        @(posedge master_clock);
        #1;
        aresetn = 1'b1;

        for (int k = 0; k < 16; k++) begin
            pv0 = pv_cnt;
            send_pulse(vecs[k].period, 8, -1, -1, -1);
            check($sformatf("v%0d_pv", k), pv_cnt - pv0, vecs[k].pv_inc);
            check($sformatf("v%0d_meas", k), int'(period_meas), vecs[k].meas);
            check($sformatf("v%0d_locked", k), int'(locked), int'(vecs[k].lk));
            check($sformatf("v%0d_err", k), int'(err_sticky), int'(vecs[k].err));
        end

        // Clear error, then arm while unlocked; burst must wait for lock.
        send_pulse(2, 0, -1, -1, 0);
        check("clr_err", int'(err_sticky), 0);
        send_pulse(2, 0, 0, -1, -1);
        check("arm_busy", int'(gate_busy), 1);
        idle(20);
        gp0 = gp_cnt;
        for (int r = 0; r < 5; r++) send_pulse(64, 8, -1, -1, -1);
        check("a_locked", int'(locked), 1);
        check("a_nogate", gp_cnt - gp0, 0);
        send_pulse(64, 8, -1, -1, -1);
        check("a_first", gp_cnt - gp0, 1);
        for (int r = 0; r < 7; r++) send_pulse(64, 8, -1, -1, -1);
        check("a_burst", gp_cnt - gp0, 8);
        check("a_done", int'(burst_done), 1);
        check("a_busy", int'(gate_busy), 0);
        send_pulse(64, 8, -1, -1, -1);
        send_pulse(64, 8, 30, -1, -1);
        check("a_after", gp_cnt - gp0, 8);
        check("rearm_busy", int'(gate_busy), 1);

        // Disarm mid-pulse: pulse completes, gate returns to idle.
        gp0 = gp_cnt;
        send_pulse(64, 8, -1, 5, -1);
        check("b_one", gp_cnt - gp0, 1);
        check("b_busy", int'(gate_busy), 0);
        check("b_done", int'(burst_done), 0);
        send_pulse(64, 8, -1, -1, 30);
        check("b_none", gp_cnt - gp0, 1);
        check("b_locked", int'(locked), 1);
        check("b_err", int'(err_sticky), 0);

        // Timeout: SYSREF stops while locked.
        pv0 = pv_cnt;
        idle(65600);
        check("to_locked", int'(locked), 0);
        check("to_err", int'(err_sticky), 1);
        check("to_pv", pv_cnt - pv0, 0);
        check("to_meas", int'(period_meas), 64);

        // Relock, arm, and reset while a gated pulse is high.
        send_pulse(64, 8, 30, -1, -1);
        for (int r = 0; r < 4; r++) send_pulse(64, 8, -1, -1, -1);
        check("d_locked", int'(locked), 1);
        send_pulse(6, 8, -1, -1, -1);
        check("d_gated_hi", int'(sysref_gated), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("d_rst_gated", int'(sysref_gated), 0);
        check("d_rst_locked", int'(locked), 0);
        check("d_rst_err", int'(err_sticky), 0);
        check("d_rst_busy", int'(gate_busy), 0);
        check("d_rst_meas", int'(period_meas), 0);
        user_sysref = 1'b0;
        idle(3);
        aresetn = 1'b1;
        idle(4);
        check("d_post_locked", int'(locked), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
